// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one SLICE-bit
// lookahead group, and the carry between groups is registered.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int NST = WIDTH / SLICE;

  if (SLICE < 1 || WIDTH < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("cla_pipe_addsub: WIDTH must be a positive multiple of SLICE");
  end

  // Flat lookahead over one group; returns {carry out, carry into group MSB, sum}.
  function automatic logic [SLICE+1:0] cla_group(input logic [SLICE-1:0] ga,
                                                 input logic [SLICE-1:0] gb,
                                                 input logic             gc);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             term;
    g = ga & gb;
    p = ga ^ gb;
    c = '0;
    c[0] = gc;
    for (int i = 1; i <= SLICE; i++) begin
      c[i] = gc;
      for (int j = 0; j < i; j++) c[i] = c[i] & p[j];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    return {c[SLICE], c[SLICE-1], p ^ c[SLICE-1:0]};
  endfunction

  logic [NST-1:0]            valid_q, valid_d;
  logic [NST-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [NST-1:0][WIDTH-1:0] a_q, a_d;
  logic [NST-1:0][WIDTH-1:0] b_q, b_d;
  logic [NST-1:0]            carry_q, carry_d;
  logic                      cout_q, cout_d;
  logic                      ovf_q, ovf_d;
  logic                      zero_q, zero_d;
  logic                      neg_q, neg_d;

  logic [NST:0]              rdy;
  logic [NST-1:0][WIDTH-1:0] stg_a, stg_b, stg_s;
  logic [NST-1:0]            stg_c, stg_v;
  logic [SLICE+1:0]          grp;

  // An empty stage always accepts, so bubbles collapse under backpressure.
  always_comb begin
    rdy = '0;
    rdy[NST] = out_ready;
    for (int k = NST - 1; k >= 0; k--) rdy[k] = ~valid_q[k] | rdy[k+1];
  end

  // Stage 0 takes the transformed operands; later stages take their predecessor.
  always_comb begin
    stg_a = '0;
    stg_b = '0;
    stg_s = '0;
    stg_c = '0;
    stg_v = '0;
    stg_a[0] = a;
    stg_b[0] = sub ? ~b : b;
    stg_c[0] = cin ^ sub;
    stg_v[0] = in_valid;
    for (int k = 1; k < NST; k++) begin
      stg_a[k] = a_q[k-1];
      stg_b[k] = b_q[k-1];
      stg_s[k] = sum_q[k-1];
      stg_c[k] = carry_q[k-1];
      stg_v[k] = valid_q[k-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    grp     = '0;
    for (int k = 0; k < NST; k++) begin
      grp = cla_group(stg_a[k][k*SLICE +: SLICE], stg_b[k][k*SLICE +: SLICE], stg_c[k]);
      if (rdy[k]) begin
        valid_d[k] = stg_v[k];
        if (stg_v[k]) begin
          sum_d[k]                   = stg_s[k];
          sum_d[k][k*SLICE +: SLICE] = grp[SLICE-1:0];
          a_d[k]                     = stg_a[k];
          b_d[k]                     = stg_b[k];
          carry_d[k]                 = grp[SLICE+1];
          if (k == NST - 1) begin
            cout_d = grp[SLICE+1];
            ovf_d  = grp[SLICE+1] ^ grp[SLICE];
            zero_d = ~|sum_d[k];
            neg_d  = sum_d[k][WIDTH-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = rdy[0] & ~rst;
  assign out_valid = valid_q[NST-1];
  assign sum       = sum_q[NST-1];
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule
